// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: FSM states,
// coin encodings, price table and credit width.
package vend_pkg;

   localparam int unsigned CREDIT_W = 4;
   localparam int unsigned SUM_W    = CREDIT_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CREDIT   = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_e;

   localparam logic [1:0] CASH_NONE = 2'b00;
   localparam logic [1:0] CASH_TK10 = 2'b01;
   localparam logic [1:0] CASH_TK20 = 2'b10;
   localparam logic [1:0] CASH_BAD  = 2'b11;

   // Price in Tk10 units: item n costs n+1.
   function automatic logic [CREDIT_W-1:0] item_price(input logic [1:0] item);
      return CREDIT_W'(item) + CREDIT_W'(1);
   endfunction

   // Coin value in Tk10 units; the invalid code counts as no coin.
   function automatic logic [1:0] cash_value(input logic [1:0] cash);
      case (cash)
         CASH_TK10: return 2'd1;
         CASH_TK20: return 2'd2;
         CASH_NONE,
         CASH_BAD:  return 2'd0;
         default:   return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter for the optional auto-refund: counts enabled cycles,
// clears on clr_i or when disabled, flags the cycle the count hits LIMIT.
module vend_timeout_ctr #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_c
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: hold at zero unless counting an idle cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_c = en_i && !clr_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, product select, dispense
// handshake and coin-by-coin change return.
// Optional feature: define VEND_TIMEOUT_EN for auto-refund after
// TIMEOUT_CYCLES idle cycles in CREDIT.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned MAX_CREDIT     = 7,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          cash_in,
   input  logic                sel_valid,
   input  logic [1:0]          sel_item,
   input  logic                cancel,
   input  logic                disp_ready,
   output logic                disp_valid,
   output logic [1:0]          disp_item,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   if (MAX_CREDIT < 2 || MAX_CREDIT > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_param
      $error("vend_ctrl: MAX_CREDIT must be 2..15 and TIMEOUT_CYCLES nonzero");
   end

   vend_state_e         state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [1:0]          item_q, item_d;
   logic                disp_valid_q, disp_valid_d;
   logic                change_q, change_d;
   logic                reject_q, reject_d;
   logic                busy_q, busy_d;

   logic                idle_st_c;
   logic [1:0]          coin_val_c;
   logic                sel_ok_c;
   logic [SUM_W-1:0]    net_c, sum_c;
   logic                coin_ok_c;
   logic [CREDIT_W-1:0] credit_sel_c;
   logic                timeout_c;

   // Coin/price arithmetic against the registered credit.
   always_comb begin
      idle_st_c    = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
      coin_val_c   = cash_value(cash_in);
      sel_ok_c     = idle_st_c && sel_valid && (credit_q >= item_price(sel_item));
      net_c        = SUM_W'(credit_q) - (sel_ok_c ? SUM_W'(item_price(sel_item)) : SUM_W'(0));
      sum_c        = net_c + SUM_W'(coin_val_c);
      coin_ok_c    = idle_st_c && (coin_val_c != 2'd0) && (sum_c <= SUM_W'(MAX_CREDIT));
      credit_sel_c = coin_ok_c ? CREDIT_W'(sum_c) : CREDIT_W'(net_c);
   end

`ifdef VEND_TIMEOUT_EN
   logic tmo_clr_c;

   assign tmo_clr_c = coin_ok_c || sel_valid || cancel || (state_q != ST_CREDIT);

   vend_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .en_i     (state_q == ST_CREDIT),
      .clr_i    (tmo_clr_c),
      .expire_c (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            if (sel_ok_c) begin
               state_d = ST_DISPENSE;
            end else if ((state_q == ST_CREDIT) && (cancel || timeout_c)) begin
               state_d = ST_CHANGE;
            end else begin
               state_d = (credit_sel_c != '0) ? ST_CREDIT : ST_IDLE;
            end
         end
         ST_DISPENSE: begin
            if (disp_ready) begin
               state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
         end
         ST_CHANGE: begin
            if (credit_q <= CREDIT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values.
   always_comb begin
      credit_d = credit_q;
      item_d   = item_q;
      reject_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            credit_d = credit_sel_c;
            reject_d = (coin_val_c != 2'd0) && !coin_ok_c;
            if (sel_ok_c) begin
               item_d = sel_item;
            end
         end
         ST_DISPENSE: begin
            reject_d = (coin_val_c != 2'd0);
         end
         ST_CHANGE: begin
            reject_d = (coin_val_c != 2'd0);
            if (credit_q != '0) begin
               credit_d = credit_q - CREDIT_W'(1);
            end
         end
         default: ;
      endcase
      disp_valid_d = (state_d == ST_DISPENSE);
      change_d     = (state_d == ST_CHANGE);
      busy_d       = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         credit_q     <= '0;
         item_q       <= '0;
         disp_valid_q <= 1'b0;
         change_q     <= 1'b0;
         reject_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         credit_q     <= credit_d;
         item_q       <= item_d;
         disp_valid_q <= disp_valid_d;
         change_q     <= change_d;
         reject_q     <= reject_d;
         busy_q       <= busy_d;
      end
   end

   assign credit       = credit_q;
   assign disp_item    = item_q;
   assign disp_valid   = disp_valid_q;
   assign change_pulse = change_q;
   assign coin_reject  = reject_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl (MAX_CREDIT=7).
// Timeout scenarios run only when VEND_TIMEOUT_EN is defined.
module tb_vend_ctrl;

   logic       clk;
   logic       reset;
   logic [1:0] cash_in;
   logic       sel_valid;
   logic [1:0] sel_item;
   logic       cancel;
   logic       disp_ready;
   logic       disp_valid;
   logic [1:0] disp_item;
   logic       change_pulse;
   logic       coin_reject;
   logic [3:0] credit;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int npulse;

   vend_ctrl #(
      .MAX_CREDIT     (7),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cash_in      (cash_in),
      .sel_valid    (sel_valid),
      .sel_item     (sel_item),
      .cancel       (cancel),
      .disp_ready   (disp_ready),
      .disp_valid   (disp_valid),
      .disp_item    (disp_item),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [1:0] c);
      cash_in = c;
      tick();
      cash_in = 2'b00;
   endtask

   task automatic sel(input logic [1:0] item);
      sel_valid = 1'b1;
      sel_item  = item;
      tick();
      sel_valid = 1'b0;
   endtask

   // Count consecutive change_pulse cycles starting at the current sample.
   task automatic count_pulses(output int n);
      n = 0;
      while (change_pulse && n < 20) begin
         n++;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; cash_in = 2'b00; sel_valid = 1'b0; sel_item = 2'd0;
      cancel = 1'b0; disp_ready = 1'b0;
      tick(); tick();
      chk("rst_credit", credit, 0);
      chk("rst_dvalid", disp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_change", change_pulse, 0);
      reset = 1'b0;

      // Tk10, Tk10, select item1 -> dispense, no change
      coin(2'b01);
      chk("c1_credit", credit, 1);
      coin(2'b01);
      chk("c2_credit", credit, 2);
      sel(2'd1);
      chk("s1_dvalid", disp_valid, 1);
      chk("s1_item", disp_item, 1);
      chk("s1_credit", credit, 0);
      chk("s1_busy", busy, 1);
      tick();
      chk("s1_hold_dvalid", disp_valid, 1);
      chk("s1_hold_item", disp_item, 1);
      disp_ready = 1'b1; tick(); disp_ready = 1'b0;
      chk("s1_done_dvalid", disp_valid, 0);
      chk("s1_done_change", change_pulse, 0);
      chk("s1_done_busy", busy, 0);

      // Tk20+Tk20, select item0 -> 3 change pulses
      coin(2'b10); coin(2'b10);
      chk("c4_credit", credit, 4);
      sel(2'd0);
      chk("s0_credit", credit, 3);
      chk("s0_item", disp_item, 0);
      disp_ready = 1'b1; tick(); disp_ready = 1'b0;
      chk("chg_first", change_pulse, 1);
      chk("chg_credit3", credit, 3);
      tick();
      chk("chg_credit2", credit, 2);
      count_pulses(npulse);
      chk("chg_count_rest", npulse, 2);
      chk("chg_end_credit", credit, 0);
      chk("chg_end_busy", busy, 0);

      // Overflow at MAX_CREDIT, invalid coin, cancel refund
      coin(2'b10); coin(2'b10); coin(2'b10);
      chk("c6_credit", credit, 6);
      coin(2'b10);
      chk("ovf_reject", coin_reject, 1);
      chk("ovf_credit", credit, 6);
      tick();
      chk("ovf_reject_gone", coin_reject, 0);
      coin(2'b01);
      chk("c7_credit", credit, 7);
      chk("c7_reject", coin_reject, 0);
      coin(2'b11);
      chk("bad_credit", credit, 7);
      chk("bad_reject", coin_reject, 0);
      cancel = 1'b1; tick(); cancel = 1'b0;
      count_pulses(npulse);
      chk("cancel7_pulses", npulse, 7);
      chk("cancel7_credit", credit, 0);

      // Insufficient select, cancel one pulse, coin during dispense
      coin(2'b01);
      sel(2'd3);
      chk("low_dvalid", disp_valid, 0);
      chk("low_credit", credit, 1);
      cancel = 1'b1; tick(); cancel = 1'b0;
      count_pulses(npulse);
      chk("cancel1_pulses", npulse, 1);
      chk("cancel1_busy", busy, 0);
      cancel = 1'b1; tick(); cancel = 1'b0;
      chk("idle_cancel_change", change_pulse, 0);
      coin(2'b01);
      sel(2'd0);
      chk("d_credit", credit, 0);
      coin(2'b01);
      chk("d_reject", coin_reject, 1);
      chk("d_credit_keep", credit, 0);
      chk("d_dvalid", disp_valid, 1);
      disp_ready = 1'b1; tick(); disp_ready = 1'b0;
      chk("d_done_change", change_pulse, 0);
      chk("d_done_dvalid", disp_valid, 0);

      // Coin and select same cycle: credit 2 + 2 - 2
      coin(2'b10);
      cash_in = 2'b10; sel_valid = 1'b1; sel_item = 2'd1;
      tick();
      cash_in = 2'b00; sel_valid = 1'b0;
      chk("cs_credit", credit, 2);
      chk("cs_item", disp_item, 1);
      chk("cs_dvalid", disp_valid, 1);
      disp_ready = 1'b1; tick(); disp_ready = 1'b0;
      count_pulses(npulse);
      chk("cs_pulses", npulse, 2);

      // Select and cancel same cycle: select wins
      coin(2'b01);
      cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd0;
      tick();
      cancel = 1'b0; sel_valid = 1'b0;
      chk("sc_dvalid", disp_valid, 1);
      chk("sc_change", change_pulse, 0);
      disp_ready = 1'b1; tick(); disp_ready = 1'b0;
      chk("sc_done_change", change_pulse, 0);
      chk("sc_done_busy", busy, 0);

      // Reset mid-dispense with credit 5
      coin(2'b10); coin(2'b10); coin(2'b10);
      sel(2'd0);
      chk("r_credit5", credit, 5);
      chk("r_dvalid", disp_valid, 1);
      reset = 1'b1; cash_in = 2'b01; tick(); reset = 1'b0; cash_in = 2'b00;
      chk("r_credit", credit, 0);
      chk("r_dvalid0", disp_valid, 0);
      chk("r_item", disp_item, 0);
      chk("r_busy", busy, 0);
      chk("r_reject", coin_reject, 0);
      tick();
      chk("r_idle_change", change_pulse, 0);

`ifdef VEND_TIMEOUT_EN
      // Credit 2 idle: no refund after 7 idle cycles, refund on the 8th
      coin(2'b10);
      repeat (7) tick();
      chk("to_7_change", change_pulse, 0);
      tick();
      chk("to_8_change", change_pulse, 1);
      count_pulses(npulse);
      chk("to_pulses", npulse, 2);

      // Coin at idle cycle 7 restarts the count
      coin(2'b10);
      repeat (6) tick();
      coin(2'b01);
      chk("tr_credit", credit, 3);
      repeat (7) tick();
      chk("tr_7_change", change_pulse, 0);
      tick();
      chk("tr_8_change", change_pulse, 1);
      count_pulses(npulse);
      chk("tr_pulses", npulse, 3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter MAX_CREDIT, default 7, maximum credit held, in Tk10 units (range 2..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, inactivity limit; used only with VEND_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cash_in  input  2  coin this cycle: 00 none, 01 Tk10, 10 Tk20, 11 invalid (treated as none).
REQ-006 sel_valid  input  1  one-cycle product-select strobe.
REQ-007 sel_item  input  2  product index 0..3; sampled with sel_valid.
REQ-008 cancel  input  1  one-cycle refund request.
REQ-009 disp_ready  input  1  dispenser accepts current item.
REQ-010 disp_valid  output  1  item request to dispenser.
REQ-011 disp_item  output  2  item index, stable while disp_valid.
REQ-012 change_pulse  output  1  one Tk10 coin returned per high cycle.
REQ-013 coin_reject  output  1  one-cycle pulse: coin not accepted (returned mechanically).
REQ-014 credit  output  4  current credit, Tk10 units.
REQ-015 busy  output  1  high in DISPENSE or CHANGE.

Function
REQ-016 States IDLE (credit 0), CREDIT (credit>0), DISPENSE, CHANGE; all outputs registered.
REQ-017 Prices, Tk10 units: item0=1, item1=2, item2=3, item3=4.
REQ-018 IDLE/CREDIT: coin accepted -> credit += value next cycle; IDLE->CREDIT when result >0.
REQ-019 Coin making credit exceed MAX_CREDIT: credit unchanged, coin_reject high one cycle.
REQ-020 sel_valid in IDLE/CREDIT with registered credit >= price: latch item, credit -= price, enter DISPENSE next cycle.
REQ-021 sel_valid with credit < price: ignored, no state change.
REQ-022 Coin and valid select same cycle: price checked against registered credit; both applied (credit + coin - price); overflow checked on that result.
REQ-023 DISPENSE: disp_valid=1, disp_item held until cycle with disp_ready=1; then CHANGE if credit>0, else IDLE; disp_valid low next cycle.
REQ-024 Any coin in DISPENSE or CHANGE: coin_reject pulse, credit unchanged.
REQ-025 CHANGE: change_pulse=1 every cycle, credit decrements by 1 per cycle; at credit 0, change_pulse low, state IDLE.
REQ-026 cancel in CREDIT: enter CHANGE next cycle (full refund); cancel in IDLE, DISPENSE, CHANGE ignored.
REQ-027 cancel and valid select same cycle in CREDIT: select wins, cancel dropped.
REQ-028 sel_valid in DISPENSE/CHANGE ignored.

Reset
REQ-029 reset high: state IDLE, credit 0, disp_valid 0, disp_item 0, change_pulse 0, coin_reject 0, busy 0, timer 0; credit mid-transaction discarded, dispense request withdrawn.
REQ-030 reset overrides all inputs in the same cycle.

Configuration
REQ-031 VEND_TIMEOUT_EN defined: in CREDIT, cycles without accepted coin, select or cancel are counted; count reaching TIMEOUT_CYCLES enters CHANGE (auto refund); counter clears on any activity or state exit.
REQ-032 VEND_TIMEOUT_EN undefined: no counter logic; credit held indefinitely in CREDIT.

Structure
REQ-033 Package vend_pkg: state enumeration, cash_in encodings, price table, credit width constant.
REQ-034 Sub-module vend_timeout_ctr (counter, clear, expire pulse), instantiated only under VEND_TIMEOUT_EN.

Verification
REQ-035 Tk10 then select item1 (price 2) after second Tk10 -> DISPENSE, disp_item=1 until disp_ready, then IDLE, zero change pulses.
REQ-036 Tk20+Tk20 (credit 4), select item0, disp_ready -> CHANGE, exactly 3 change_pulse cycles, credit 4->3->0 through decrements, IDLE.
REQ-037 Credit 6, MAX_CREDIT 7, Tk20 -> coin_reject one cycle, credit stays 6; Tk10 -> credit 7.
REQ-038 Credit 1, select item3 -> ignored; cancel -> one change_pulse, IDLE; coin during DISPENSE -> coin_reject.
REQ-039 Credit 5 with disp_valid high, reset asserted -> next cycle all outputs zero, state IDLE.
REQ-040 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8, credit 2, idle 8 cycles -> CHANGE, 2 change_pulse cycles; coin at cycle 7 restarts count.
